// File: rtl/gpu_pkg.sv
// Shared types and frame constants for the pixel pipeline.
// Pixel addresses are packed {x, y}; the writer FSM state type lives here too.
package gpu_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int PIX_W = X_W + Y_W;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        RELEASE
    } writer_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO. The read port is a register loaded on pop, so popped data
// is visible the cycle after the pop edge and holds until the next pop.
module pixel_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Clips incoming pixels, queues them, and writes each to frame-buffer SRAM with
// a SETUP / WRITE / RELEASE strobe sequence; raises draw_done once a primitive drains.
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int H_RES       = gpu_pkg::H_RES,
    parameter int V_RES       = gpu_pkg::V_RES,
    parameter int FIFO_DEPTH  = 8,
    parameter int STOP_MARGIN = 3,
    parameter int WE_CYCLES   = 2,
    parameter int COLOR_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_addr,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               prim_done,
    output logic               stop,
    output logic [PIX_W-1:0]   sram_addr,
    output logic [COLOR_W-1:0] sram_data,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               draw_done,
    output logic [15:0]        dropped_count,
    output logic               overflow
);

    localparam int ENTRY_W = PIX_W + COLOR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int WC_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [X_W-1:0]   X_LIM    = X_W'(H_RES);
    localparam logic [Y_W-1:0]   Y_LIM    = Y_W'(V_RES);
    localparam logic [OCC_W-1:0] STOP_LVL = OCC_W'(FIFO_DEPTH - STOP_MARGIN);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WE_CYCLES - 1);

    writer_state_t      state;
    writer_state_t      state_next;
    logic [WC_W-1:0]    we_cnt;
    logic [WC_W-1:0]    we_cnt_next;
    pix_addr_t          in_pix;
    pix_addr_t          head_pix;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occ_next;
    logic               in_range;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               done_pending;
    logic               done_fire;

    assign in_pix   = pix_addr;
    assign in_range = (in_pix.x < X_LIM) && (in_pix.y < Y_LIM);
    assign push     = pix_valid && in_range && !fifo_full;
    assign occ_next = {1'b0, fifo_count} + OCC_W'(push) - OCC_W'(pop);

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_pix, pix_color}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The head register only loads on pop, so address and data stay put for
    // the whole SETUP/WRITE/RELEASE window of that pixel.
    assign head_pix  = head[ENTRY_W-1:COLOR_W];
    assign sram_data = head[COLOR_W-1:0];
    assign sram_addr = PIX_W'(head_pix.y) * PIX_W'(H_RES) + PIX_W'(head_pix.x);

    assign sram_ce_n = (state == IDLE);
    assign sram_we_n = (state != WRITE);
    assign done_fire = done_pending && fifo_empty && (state == IDLE);

    always_comb begin
        state_next  = state;
        we_cnt_next = we_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                we_cnt_next = '0;
                state_next  = WRITE;
            end
            WRITE: begin
                if (we_cnt == WC_LAST) state_next = RELEASE;
                else                   we_cnt_next = we_cnt + WC_W'(1);
            end
            RELEASE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            we_cnt        <= '0;
            stop          <= 1'b0;
            draw_done     <= 1'b0;
            done_pending  <= 1'b0;
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else begin
            state     <= state_next;
            we_cnt    <= we_cnt_next;
            stop      <= (occ_next >= STOP_LVL);
            draw_done <= done_fire;
            // A new prim_done landing on the firing cycle starts a fresh pending done.
            done_pending <= (done_pending && !done_fire) || prim_done;
            if (pix_valid && !in_range && (dropped_count != 16'hFFFF))
                dropped_count <= dropped_count + 16'd1;
            if (pix_valid && in_range && fifo_full)
                overflow <= 1'b1;
        end
    end

endmodule
